// File: rtl/reg_native_arbiter.sv
// Round-robin arbiter sharing one downstream reg native port among NUM_REQ upstream masters.
// Optional ack timeout enabled by defining REG_ARB_TIMEOUT_EN.
module reg_native_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 48,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               up_req_vld,
    input  logic [NUM_REQ-1:0]               up_wr_en,
    input  logic [NUM_REQ-1:0]               up_rd_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    up_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    up_wr_data,
    output logic [NUM_REQ-1:0]               up_ack_vld,
    output logic [DATA_WIDTH-1:0]            up_rd_data,
    output logic                             up_err,
    output logic                             req_vld,
    output logic                             wr_en,
    output logic                             rd_en,
    output logic [ADDR_WIDTH-1:0]            addr,
    output logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             ack_vld,
    input  logic [DATA_WIDTH-1:0]            rd_data,
    input  logic                             err
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("reg_native_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } slot_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] clr;
    logic [NUM_REQ-1:0] capture;
    slot_t              slot [NUM_REQ];
    logic [IDX_W-1:0]   rr;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   grant_nxt;
    logic               any_pend;
    logic               ack_hit;
    logic               timeout;
    logic               complete;

    // Read is implied whenever wr_en is low, so the explicit read qualifier carries no information.
    logic unused_rd_en;
    assign unused_rd_en = ^up_rd_en;

    assign any_pend = |pending;
    assign ack_hit  = ack_vld && (state == ISSUE || state == WAIT);
    assign complete = ack_hit || timeout;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    assign timeout = (state == WAIT) && !ack_vld && (cnt == CNT_W'(TIMEOUT_CYCLES));

    // Counts ISSUE/WAIT cycles without an ack; restarts for every new grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nxt == ISSUE) begin
            cnt <= '0;
        end else if ((state == ISSUE || state == WAIT) && !ack_vld) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // First pending port after the last winner, wrapping.
    always_comb begin
        logic             found;
        int unsigned      idx;
        logic [IDX_W-1:0] p;
        grant_nxt = grant;
        found     = 1'b0;
        idx       = 0;
        p         = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(rr) + k) % NUM_REQ;
            p   = IDX_W'(idx);
            if (!found && pending[p]) begin
                grant_nxt = p;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        clr = '0;
        if (complete) clr[grant] = 1'b1;
    end

    // A completing port may accept a new request on the same edge.
    assign capture = up_req_vld & (~pending | clr);

    always_comb begin
        state_nxt  = state;
        req_vld    = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        addr       = '0;
        wr_data    = '0;
        up_ack_vld = '0;
        up_rd_data = '0;
        up_err     = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_pend) state_nxt = ISSUE;
            end
            ISSUE: begin
                req_vld   = 1'b1;
                wr_en     = slot[grant].wr;
                rd_en     = !slot[grant].wr;
                addr      = slot[grant].addr;
                wr_data   = slot[grant].data;
                state_nxt = ack_vld ? IDLE : WAIT;
            end
            WAIT: begin
                if (ack_vld || timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (complete) begin
            up_ack_vld[grant] = 1'b1;
            up_rd_data        = ack_hit ? rd_data : '0;
            up_err            = ack_hit ? err : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            rr      <= IDX_W'(NUM_REQ - 1);
            grant   <= '0;
        end else begin
            state   <= state_nxt;
            pending <= (pending & ~clr) | up_req_vld;
            if (state == IDLE && any_pend) grant <= grant_nxt;
            if (complete) rr <= grant;
        end
    end

    // Request payload slots; contents only matter while the matching pending bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (capture[i]) begin
                slot[i] <= '{wr:   up_wr_en[i],
                             addr: up_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                             data: up_wr_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

endmodule

// File: tb/tb_reg_native_arbiter.sv
// Scoreboard bench for reg_native_arbiter: directed stimulus queues expected downstream
// requests and upstream acks; a monitor pops and compares whenever the DUT presents them.
module tb_reg_native_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 48;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   up_req_vld = '0;
    logic [NR-1:0]   up_wr_en = '0;
    logic [NR-1:0]   up_rd_en = '0;
    logic [NR*AW-1:0] up_addr = '0;
    logic [NR*DW-1:0] up_wr_data = '0;
    logic [NR-1:0]   up_ack_vld;
    logic [DW-1:0]   up_rd_data;
    logic            up_err;
    logic            req_vld, wr_en, rd_en;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wr_data;
    logic            ack_vld;
    logic [DW-1:0]   rd_data;
    logic            err;

    reg_native_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .up_req_vld(up_req_vld), .up_wr_en(up_wr_en), .up_rd_en(up_rd_en),
        .up_addr(up_addr), .up_wr_data(up_wr_data),
        .up_ack_vld(up_ack_vld), .up_rd_data(up_rd_data), .up_err(up_err),
        .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
        .ack_vld(ack_vld), .rd_data(rd_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            cyc;
    } dn_t;

    typedef struct {
        logic [NR-1:0] mask;
        logic [DW-1:0] rd;
        logic          e;
        int            cyc;
    } up_t;

    dn_t exp_dn[$];
    up_t exp_up[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    always @(posedge clk) cyc++;

    // Slave model: acks slv_delay cycles after req_vld (0 = same cycle), or never when slv_noack.
    logic          slv_ack = 1'b0;
    logic          stray = 1'b0;
    logic          slv_noack = 1'b0;
    int            slv_delay = 0;
    int            cd = 0;
    logic [DW-1:0] slv_rd_data = '0;
    logic          slv_err = 1'b0;

    assign ack_vld = slv_ack | stray;
    assign rd_data = slv_rd_data;
    assign err     = slv_err;

    always @(negedge clk) begin
        slv_ack = 1'b0;
        if (rst) begin
            cd = 0;
        end else if (!slv_noack) begin
            if (req_vld) begin
                if (slv_delay == 0) slv_ack = 1'b1;
                else cd = slv_delay;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) slv_ack = 1'b1;
            end
        end
    end

    // Monitor: samples just after the falling edge.
    always begin
        @(negedge clk);
        #1;
        if (req_vld) begin
            checks++;
            if (exp_dn.size() == 0) begin
                errors++;
                $display("FAIL dn_unexpected: cyc=%0d wr=%0b addr=%0h data=%0h but none required",
                         cyc, wr_en, addr, wr_data);
            end else begin
                dn_t e;
                e = exp_dn.pop_front();
                if (wr_en !== e.wr || rd_en !== !e.wr || addr !== e.a || wr_data !== e.d || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL dn_req: got cyc=%0d wr=%0b rd=%0b addr=%0h data=%0h, required cyc=%0d wr=%0b rd=%0b addr=%0h data=%0h",
                             cyc, wr_en, rd_en, addr, wr_data, e.cyc, e.wr, !e.wr, e.a, e.d);
                end
            end
        end
        if (up_ack_vld != '0) begin
            checks++;
            if (exp_up.size() == 0) begin
                errors++;
                $display("FAIL up_unexpected: cyc=%0d ack=%b rd=%0h err=%0b but none required",
                         cyc, up_ack_vld, up_rd_data, up_err);
            end else begin
                up_t e;
                e = exp_up.pop_front();
                if (up_ack_vld !== e.mask || up_rd_data !== e.rd || up_err !== e.e || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL up_ack: got cyc=%0d ack=%b rd=%0h err=%0b, required cyc=%0d ack=%b rd=%0h err=%0b",
                             cyc, up_ack_vld, up_rd_data, up_err, e.cyc, e.mask, e.rd, e.e);
                end
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic set_port(int p, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
        up_wr_en[p]           = wr;
        up_rd_en[p]           = !wr;
        up_addr[p*AW +: AW]   = a;
        up_wr_data[p*DW +: DW] = d;
    endtask

    task automatic push_dn(bit wr, logic [AW-1:0] a, logic [DW-1:0] d, int c);
        dn_t e;
        e.wr = wr; e.a = a; e.d = d; e.cyc = c;
        exp_dn.push_back(e);
    endtask

    task automatic push_up(logic [NR-1:0] m, logic [DW-1:0] rd, logic e_, int c);
        up_t e;
        e.mask = m; e.rd = rd; e.e = e_; e.cyc = c;
        exp_up.push_back(e);
    endtask

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while ((exp_dn.size() != 0 || exp_up.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_dn.size() != 0 || exp_up.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d dn and %0d up expectations outstanding, required 0",
                     name, exp_dn.size(), exp_up.size());
            exp_dn.delete();
            exp_up.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        repeat (3) @(negedge clk);
        chk("rst_req_vld", 64'(req_vld), 64'd0);
        chk("rst_up_ack", 64'(up_ack_vld), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_up_err", 64'(up_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Port0 write, same-cycle ack.
        slv_delay = 0; slv_rd_data = '0; slv_err = 1'b0;
        @(negedge clk); c = cyc;
        set_port(0, 1'b1, 48'h10, 32'hDEADBEEF);
        up_req_vld = 2'b01;
        push_dn(1'b1, 48'h10, 32'hDEADBEEF, c + 2);
        push_up(2'b01, 32'h0, 1'b0, c + 2);
        @(negedge clk); up_req_vld = '0;
        wait_drain("wr_same_cycle");

        // Port1 read, ack 3 cycles after req_vld with error.
        slv_delay = 3; slv_rd_data = 32'hA5A5A5A5; slv_err = 1'b1;
        @(negedge clk); c = cyc;
        set_port(1, 1'b0, 48'h20, 32'h1234);
        up_req_vld = 2'b10;
        push_dn(1'b0, 48'h20, 32'h1234, c + 2);
        push_up(2'b10, 32'hA5A5A5A5, 1'b1, c + 5);
        @(negedge clk); up_req_vld = '0;
        wait_drain("rd_delayed");

        // Both ports every round: order must alternate 0,1.
        slv_delay = 0; slv_rd_data = '0; slv_err = 1'b0;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk); c = cyc;
            set_port(0, 1'b1, 48'h100 + 48'(r), 32'hA000 + 32'(r));
            set_port(1, 1'b1, 48'h200 + 48'(r), 32'hB000 + 32'(r));
            up_req_vld = 2'b11;
            push_dn(1'b1, 48'h100 + 48'(r), 32'hA000 + 32'(r), c + 2);
            push_up(2'b01, 32'h0, 1'b0, c + 2);
            push_dn(1'b1, 48'h200 + 48'(r), 32'hB000 + 32'(r), c + 4);
            push_up(2'b10, 32'h0, 1'b0, c + 4);
            @(negedge clk); up_req_vld = '0;
            wait_drain("rr_round");
        end

        // Reset while in WAIT, then a stray ack: nothing may come back upstream.
        slv_noack = 1'b1;
        @(negedge clk); c = cyc;
        set_port(1, 1'b0, 48'h300, 32'h0);
        up_req_vld = 2'b10;
        push_dn(1'b0, 48'h300, 32'h0, c + 2);
        @(negedge clk); up_req_vld = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        stray = 1'b1;
        #2;
        chk("stray_no_up_ack", 64'(up_ack_vld), 64'd0);
        @(negedge clk); stray = 1'b0;
        slv_noack = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle_req", 64'(req_vld), 64'd0);
        wait_drain("rst_in_wait");
        @(negedge clk); c = cyc;
        set_port(0, 1'b1, 48'h310, 32'h31);
        set_port(1, 1'b1, 48'h320, 32'h32);
        up_req_vld = 2'b11;
        push_dn(1'b1, 48'h310, 32'h31, c + 2);
        push_up(2'b01, 32'h0, 1'b0, c + 2);
        push_dn(1'b1, 48'h320, 32'h32, c + 4);
        push_up(2'b10, 32'h0, 1'b0, c + 4);
        @(negedge clk); up_req_vld = '0;
        wait_drain("post_rst_order");

        // Repeated pulses on port0 while pending are ignored, payload untouched.
        slv_delay = 2;
        @(negedge clk); c = cyc;
        set_port(0, 1'b1, 48'h400, 32'h11111111);
        up_req_vld = 2'b01;
        push_dn(1'b1, 48'h400, 32'h11111111, c + 2);
        push_up(2'b01, 32'h0, 1'b0, c + 4);
        @(negedge clk); set_port(0, 1'b1, 48'h500, 32'h22222222);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); up_req_vld = '0;
        wait_drain("dup_ignored");

        // New request in the same cycle as its ack is captured.
        slv_delay = 0;
        @(negedge clk); c = cyc;
        set_port(0, 1'b1, 48'h600, 32'h66);
        up_req_vld = 2'b01;
        push_dn(1'b1, 48'h600, 32'h66, c + 2);
        push_up(2'b01, 32'h0, 1'b0, c + 2);
        @(negedge clk); up_req_vld = '0;
        @(negedge clk);
        set_port(0, 1'b0, 48'h700, 32'h77);
        up_req_vld = 2'b01;
        push_dn(1'b0, 48'h700, 32'h77, c + 4);
        push_up(2'b01, 32'h0, 1'b0, c + 4);
        @(negedge clk); up_req_vld = '0;
        wait_drain("set_wins");

`ifdef REG_ARB_TIMEOUT_EN
        // Slave never acks: timeout completion on the 8th cycle after req_vld.
        slv_noack = 1'b1; slv_rd_data = 32'hFFFFFFFF; slv_err = 1'b0;
        @(negedge clk); c = cyc;
        set_port(1, 1'b0, 48'h800, 32'h0);
        up_req_vld = 2'b10;
        push_dn(1'b0, 48'h800, 32'h0, c + 2);
        push_up(2'b10, 32'h0, 1'b1, c + 10);
        @(negedge clk); up_req_vld = '0;
        wait_drain("timeout");
        stray = 1'b1;
        #2;
        chk("late_ack_ignored", 64'(up_ack_vld), 64'd0);
        @(negedge clk); stray = 1'b0;
        slv_noack = 1'b0; slv_rd_data = 32'h5;
        @(negedge clk); c = cyc;
        set_port(0, 1'b0, 48'h900, 32'h0);
        up_req_vld = 2'b01;
        push_dn(1'b0, 48'h900, 32'h0, c + 2);
        push_up(2'b01, 32'h5, 1'b0, c + 2);
        @(negedge clk); up_req_vld = '0;
        wait_drain("after_timeout");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
